// File: rtl/uart_alu_sequencer_if.sv
// Bus bundle between the command sequencer and its UART_RX / UART_TX / ALU
// environment. The sequencer side uses the master modport.
interface uart_alu_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx;
  logic               i_rxDone;
  logic               i_txDone;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic               o_valid;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_data;
  logic               o_busy;
  logic               o_err;

  modport master (
    input  i_rx, i_rxDone, i_txDone, i_result,
    output o_datoA, o_datoB, o_operation, o_valid, o_tx_start, o_data, o_busy, o_err
  );

  modport slave (
    output i_rx, i_rxDone, i_txDone, i_result,
    input  o_datoA, o_datoB, o_operation, o_valid, o_tx_start, o_data, o_busy, o_err
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Command sequencer: parses (tag, payload) byte pairs from UART_RX into
// operand A, operand B and opcode, fires the ALU once per OP command, hands
// the result to UART_TX and waits for the frame to finish.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a tag byte
// S_PAYLOAD | tag accepted, waiting for its payload byte (timed)
// S_EXEC    | ALU execute strobe, result captured at end of cycle
// S_SEND    | UART_TX start strobe
// S_WAIT_TX | waiting for UART_TX to report the frame done
module uart_alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_TMO  = 16,
  parameter int TMO_CYC = 50000
) (
  input logic                  clk,
  input logic                  i_rst_n,
  uart_alu_sequencer_if.master bus
);

  localparam logic [NB_OP-1:0]  TAG_A    = NB_OP'(8'h08);
  localparam logic [NB_OP-1:0]  TAG_B    = NB_OP'(8'h10);
  localparam logic [NB_OP-1:0]  TAG_OP   = NB_OP'(8'h20);
  localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_OP-1:0]   tag_q, tag_d;
  logic [NB_TMO-1:0]  timer_q, timer_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               a_ok_q, a_ok_d;
  logic               b_ok_q, b_ok_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               err_q, err_d;

  logic [NB_OP-1:0] rx_tag;
  logic             tag_legal;

  assign rx_tag    = bus.i_rx[NB_OP-1:0];
  assign tag_legal = (rx_tag == TAG_A) || (rx_tag == TAG_B) || (rx_tag == TAG_OP);

  // State and datapath registers; reset drops any partial command and the operand flags.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      timer_q  <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
      a_ok_q   <= 1'b0;
      b_ok_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      timer_q  <= timer_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      op_q     <= op_d;
      a_ok_q   <= a_ok_d;
      b_ok_q   <= b_ok_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: byte parsing, payload timeout and the execute/transmit handshake.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    timer_d  = timer_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    op_d     = op_q;
    a_ok_d   = a_ok_q;
    b_ok_d   = b_ok_q;
    data_d   = data_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_rxDone) begin
          if (tag_legal) begin
            tag_d   = rx_tag;
            timer_d = '0;
            state_d = S_PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_PAYLOAD: begin
        // An arriving byte takes priority over a simultaneous timeout.
        if (bus.i_rxDone) begin
          state_d = S_IDLE;
          if (tag_q == TAG_A) begin
            dato_a_d = bus.i_rx;
            a_ok_d   = 1'b1;
          end else if (tag_q == TAG_B) begin
            dato_b_d = bus.i_rx;
            b_ok_d   = 1'b1;
          end else if (a_ok_q && b_ok_q) begin
            op_d    = rx_tag;
            state_d = S_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_EXEC: begin
        data_d  = bus.i_result;
        state_d = S_SEND;
        err_d   = bus.i_rxDone;
      end

      S_SEND: begin
        state_d = S_WAIT_TX;
        err_d   = bus.i_rxDone;
      end

      S_WAIT_TX: begin
        if (bus.i_txDone) state_d = S_IDLE;
        err_d = bus.i_rxDone;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_datoA     = dato_a_q;
  assign bus.o_datoB     = dato_b_q;
  assign bus.o_operation = op_q;
  assign bus.o_data      = data_q;
  assign bus.o_err       = err_q;
  assign bus.o_valid     = (state_q == S_EXEC);
  assign bus.o_tx_start  = (state_q == S_SEND);
  assign bus.o_busy      = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomized bench for uart_alu_sequencer. A command-level model tracks the
// operand/opcode contents and the expected number of error, execute and
// transmit events; the DUT's event counts and registers are compared to it.
module tb_uart_alu_sequencer;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NB_TMO  = 16;
  localparam int TMO_CYC = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_alu_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  uart_alu_sequencer #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TMO(NB_TMO), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Stand-in ALU for the environment.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    return (a + b) ^ {2'b00, op};
  endfunction

  assign bus.i_result = alu_ref(bus.o_datoA, bus.o_datoB, bus.o_operation);

  int n_vec = 0;
  int n_mis = 0;
  int err_cnt = 0;
  int val_cnt = 0;
  int txs_cnt = 0;

  always @(posedge clk) begin
    if (bus.o_err)      err_cnt++;
    if (bus.o_valid)    val_cnt++;
    if (bus.o_tx_start) txs_cnt++;
  end

  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  bit         m_aok, m_bok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx     = b;
    bus.i_rxDone = 1'b1;
    @(negedge clk);
    bus.i_rxDone = 1'b0;
    bus.i_rx     = 8'($urandom);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_datoA"}, 32'(bus.o_datoA), 32'(m_a));
    chk({tag, "_datoB"}, 32'(bus.o_datoB), 32'(m_b));
    chk({tag, "_op"}, 32'(bus.o_operation), 32'(m_op));
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_aok = 0; m_bok = 0;
  endtask

  task automatic load(input logic [7:0] tag, input logic [7:0] val, input int gap);
    int e0;
    e0 = err_cnt;
    send_byte(tag);
    tick(gap);
    send_byte(val);
    if (tag == 8'h08) begin m_a = val; m_aok = 1; end
    else begin m_b = val; m_bok = 1; end
    tick(1);
    chk("load_err", 32'(err_cnt - e0), 32'd0);
    chk("load_busy", 32'(bus.o_busy), 32'd0);
    check_regs("load");
  endtask

  task automatic timeout(input logic [7:0] tag);
    int e0;
    e0 = err_cnt;
    send_byte(tag);
    tick(TMO_CYC - 1);
    chk("tmo_early", 32'(err_cnt - e0), 32'd0);
    tick(3);
    chk("tmo_err", 32'(err_cnt - e0), 32'd1);
    check_regs("tmo");
  endtask

  task automatic illegal_tag();
    logic [7:0] b;
    int e0;
    b = 8'($urandom);
    while (b[5:0] == 6'h08 || b[5:0] == 6'h10 || b[5:0] == 6'h20) b = 8'($urandom);
    e0 = err_cnt;
    send_byte(b);
    tick(1);
    chk("illegal_err", 32'(err_cnt - e0), 32'd1);
    chk("illegal_busy", 32'(bus.o_busy), 32'd0);
    check_regs("illegal");
  endtask

  task automatic stray_txdone();
    int t0;
    t0 = txs_cnt;
    bus.i_txDone = 1'b1;
    tick(1);
    bus.i_txDone = 1'b0;
    tick(1);
    chk("stray_busy", 32'(bus.o_busy), 32'd0);
    chk("stray_tx", 32'(txs_cnt - t0), 32'd0);
  endtask

  task automatic do_op(input logic [7:0] val, input int gap, input int hold, input bit intrude);
    int e0, v0, t0;
    logic [7:0] res;
    e0 = err_cnt; v0 = val_cnt; t0 = txs_cnt;
    send_byte(8'h20);
    tick(gap);
    send_byte(val);
    if (m_aok && m_bok) begin
      m_op = val[5:0];
      res  = alu_ref(m_a, m_b, m_op);
      chk("exec_valid", 32'(bus.o_valid), 32'd1);
      chk("exec_busy", 32'(bus.o_busy), 32'd1);
      chk("exec_txs", 32'(bus.o_tx_start), 32'd0);
      check_regs("exec");
      tick(1);
      chk("send_txs", 32'(bus.o_tx_start), 32'd1);
      chk("send_valid", 32'(bus.o_valid), 32'd0);
      chk("send_data", 32'(bus.o_data), 32'(res));
      tick(1);
      chk("wait_txs", 32'(bus.o_tx_start), 32'd0);
      if (intrude) begin
        send_byte(8'($urandom));
        check_regs("intrude");
      end
      tick(hold);
      chk("wait_busy", 32'(bus.o_busy), 32'd1);
      chk("wait_txcnt", 32'(txs_cnt - t0), 32'd1);
      bus.i_txDone = 1'b1;
      tick(1);
      bus.i_txDone = 1'b0;
      chk("done_busy", 32'(bus.o_busy), 32'd0);
      tick(1);
      chk("op_err", 32'(err_cnt - e0), intrude ? 32'd1 : 32'd0);
      chk("op_valid_cnt", 32'(val_cnt - v0), 32'd1);
      chk("op_tx_cnt", 32'(txs_cnt - t0), 32'd1);
      chk("op_data_hold", 32'(bus.o_data), 32'(res));
    end else begin
      chk("noop_valid", 32'(bus.o_valid), 32'd0);
      tick(1);
      chk("noop_err", 32'(err_cnt - e0), 32'd1);
      chk("noop_valid_cnt", 32'(val_cnt - v0), 32'd0);
      chk("noop_busy", 32'(bus.o_busy), 32'd0);
      check_regs("noop");
    end
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 4) == 0) return TMO_CYC - 1 - int'($urandom_range(0, 2));
    return int'($urandom_range(0, 5));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] tags [3];
    int k;
    tags[0] = 8'h08; tags[1] = 8'h10; tags[2] = 8'h20;
    bus.i_rx = '0; bus.i_rxDone = 1'b0; bus.i_txDone = 1'b0;
    model_reset();
    tick(3);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_txs", 32'(bus.o_tx_start), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    tick(2);

    // OP with no operands loaded after reset.
    do_op(8'h01, 0, 0, 0);

    // Basic sequence with a long TX hold.
    load(8'h08, 8'h05, 0);
    load(8'h10, 8'h03, 0);
    do_op(8'h07, 0, 100, 0);

    // Payload timeout, then recovery; payload at the last allowed cycle.
    timeout(8'h08);
    load(8'h08, 8'hAA, 0);
    load(8'h10, 8'h5C, TMO_CYC - 1);
    illegal_tag();
    do_op(8'h3F, 2, 5, 1);

    for (int it = 0; it < 80; it++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 9: load(tags[$urandom_range(0, 1)], 8'($urandom), rand_gap());
        3, 4, 5:    do_op(8'($urandom), rand_gap(), int'($urandom_range(0, 20)), $urandom_range(0, 2) == 0);
        6:          illegal_tag();
        7:          timeout(tags[$urandom_range(0, 2)]);
        default:    stray_txdone();
      endcase
    end

    // Asynchronous reset while waiting for TX.
    send_byte(8'h20);
    send_byte(8'h15);
    tick(3);
    chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_txs", 32'(bus.o_tx_start), 32'd0);
    chk("arst_err", 32'(bus.o_err), 32'd0);
    chk("arst_data", 32'(bus.o_data), 32'd0);
    check_regs("arst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    stray_txdone();
    do_op(8'h02, 0, 0, 0);
    load(8'h08, 8'h11, 1);
    do_op(8'h03, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
